// File: rtl/function_table_arbiter.sv
// function_table_arbiter
//
// Shares one registered function-lookup table (one-cycle read latency)
// between NUM_REQ requesters. Requests are granted round-robin, at most one
// lookup is issued per cycle, the owner tag of each lookup is carried alongside
// the table pipeline, and each result lands in a per-requester response
// register that is held until the requester consumes it.
//
// Ports:
//   iCLK       clock, all state on the rising edge
//   iRST_N     asynchronous active-low reset
//   iReqValid  request valid, bit i = requester i
//   iReqData   request arguments, requester i at [i*WIDTH_X +: WIDTH_X]
//   oReqReady  one-hot grant (combinational), zero when nobody is eligible
//   oTabData   registered argument driven to the table
//   iTabData   table result, valid one cycle after oTabData
//   oRspValid  response held for requester i
//   oRspData   responses, requester i at [i*WIDTH_Y +: WIDTH_Y]
//   iRspReady  requester i consumes its held response
//   oBusy      any lookup in flight or any response held
module function_table_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH_X = 8,
  parameter int WIDTH_Y = 8
) (
  input  logic                       iCLK,
  input  logic                       iRST_N,
  input  logic [NUM_REQ-1:0]         iReqValid,
  input  logic [NUM_REQ*WIDTH_X-1:0] iReqData,
  output logic [NUM_REQ-1:0]         oReqReady,
  output logic [WIDTH_X-1:0]         oTabData,
  input  logic [WIDTH_Y-1:0]         iTabData,
  output logic [NUM_REQ-1:0]         oRspValid,
  output logic [NUM_REQ*WIDTH_Y-1:0] oRspData,
  input  logic [NUM_REQ-1:0]         iRspReady,
  output logic                       oBusy
);

  localparam int TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [TAG_W:0] NUM_REQ_W = (TAG_W+1)'(NUM_REQ);
  localparam logic [TAG_W:0] ONE_W     = (TAG_W+1)'(1);

  logic               s1Vld;
  logic               s2Vld;
  logic [TAG_W-1:0]   s1Tag;
  logic [TAG_W-1:0]   s2Tag;
  logic [TAG_W-1:0]   rr;

  logic [NUM_REQ-1:0]   slotFree;
  logic [NUM_REQ-1:0]   eligible;
  logic [2*NUM_REQ-1:0] rotated;
  logic                 found;
  logic [TAG_W-1:0]     offset;
  logic [TAG_W:0]       winnerSum;
  logic [TAG_W:0]       nextSum;
  logic [TAG_W-1:0]     winner;
  logic [TAG_W-1:0]     nextRr;
  logic [WIDTH_X-1:0]   winnerArg;

  // A slot is free only when nothing it owns is anywhere in the table
  // pipeline and its response register is empty. A response that is being
  // consumed this very cycle still counts as occupying the slot, which keeps
  // the grant path independent of iRspReady.
  always_comb begin
    slotFree = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      slotFree[i] = !(s1Vld && (s1Tag == TAG_W'(i))) &&
                    !(s2Vld && (s2Tag == TAG_W'(i))) &&
                    !oRspValid[i];
    end
  end

  // While reset is asserted no request is considered, so the grant reads
  // zero together with every other output.
  assign eligible = iReqValid & slotFree & {NUM_REQ{iRST_N}};

  // Rotating the doubled eligibility vector by rr turns the wrap-around
  // search into a plain lowest-set-bit search; the offset found is then
  // added back onto rr modulo NUM_REQ (which need not be a power of two).
  assign rotated = {eligible, eligible} >> rr;

  always_comb begin
    found  = 1'b0;
    offset = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      if (rotated[k]) begin
        found  = 1'b1;
        offset = TAG_W'(k);
      end
    end
    winnerSum = {1'b0, rr} + {1'b0, offset};
    if (winnerSum >= NUM_REQ_W) begin
      winnerSum = winnerSum - NUM_REQ_W;
    end
    winner  = winnerSum[TAG_W-1:0];
    nextSum = {1'b0, winner} + ONE_W;
    if (nextSum >= NUM_REQ_W) begin
      nextSum = '0;
    end
    nextRr = nextSum[TAG_W-1:0];
  end

  // Decode the winner into the one-hot grant and pick its argument slice.
  always_comb begin
    oReqReady = '0;
    winnerArg = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (found && (winner == TAG_W'(i))) begin
        oReqReady[i] = 1'b1;
        winnerArg    = iReqData[i*WIDTH_X +: WIDTH_X];
      end
    end
  end

  // Issue, tag tracking and response capture. Stage 1 mirrors the argument
  // register feeding the table, stage 2 mirrors the table's own output
  // register, so the tag leaving stage 2 names the owner of iTabData.
  // Capture and consume can never hit the same slot in one cycle because
  // a slot with a held response cannot have a lookup in flight.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oTabData  <= '0;
      s1Vld     <= 1'b0;
      s1Tag     <= '0;
      s2Vld     <= 1'b0;
      s2Tag     <= '0;
      rr        <= '0;
      oRspValid <= '0;
      oRspData  <= '0;
    end else begin
      s1Vld <= found;
      if (found) begin
        oTabData <= winnerArg;
        s1Tag    <= winner;
        rr       <= nextRr;
      end
      s2Vld <= s1Vld;
      s2Tag <= s1Tag;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (oRspValid[i] && iRspReady[i]) begin
          oRspValid[i] <= 1'b0;
        end
        if (s2Vld && (s2Tag == TAG_W'(i))) begin
          oRspValid[i]                    <= 1'b1;
          oRspData[i*WIDTH_Y +: WIDTH_Y]  <= iTabData;
        end
      end
    end
  end

  assign oBusy = s1Vld | s2Vld | (|oRspValid);

endmodule

// File: tb/tb_function_table_arbiter.sv
// tb_function_table_arbiter
//
// Drives function_table_arbiter with directed scenarios followed by random
// traffic, and compares every output each cycle against a behavioural model
// that tracks each requester's lookup by age and response by a held flag.
// The shared table is modelled as a registered arithmetic function.
module tb_function_table_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WIDTH_X = 8;
  localparam int WIDTH_Y = 8;

  logic                       iCLK = 1'b0;
  logic                       iRST_N = 1'b0;
  logic [NUM_REQ-1:0]         iReqValid = '0;
  logic [NUM_REQ*WIDTH_X-1:0] iReqData = '0;
  logic [NUM_REQ-1:0]         oReqReady;
  logic [WIDTH_X-1:0]         oTabData;
  logic [WIDTH_Y-1:0]         tabOut = '0;
  logic [NUM_REQ-1:0]         oRspValid;
  logic [NUM_REQ*WIDTH_Y-1:0] oRspData;
  logic [NUM_REQ-1:0]         iRspReady = '0;
  logic                       oBusy;

  int nCompared = 0;
  int nMismatched = 0;

  // Requester behaviour
  bit         reqVal[NUM_REQ];
  logic [7:0] reqArg[NUM_REQ];
  bit         rspRdy[NUM_REQ];
  bit         autoRenew[NUM_REQ];

  // Reference model state
  int         mRr;
  int         mAge[NUM_REQ];
  logic [7:0] mArg[NUM_REQ];
  bit         mHeld[NUM_REQ];
  logic [7:0] mRsp[NUM_REQ];
  logic [7:0] mTab;

  // Fairness observation of the DUT's grants
  bit fairPhase = 1'b0;
  int lastGrant = -1;
  int dutWait[NUM_REQ];

  function_table_arbiter #(
    .NUM_REQ(NUM_REQ),
    .WIDTH_X(WIDTH_X),
    .WIDTH_Y(WIDTH_Y)
  ) dut (
    .iCLK(iCLK),
    .iRST_N(iRST_N),
    .iReqValid(iReqValid),
    .iReqData(iReqData),
    .oReqReady(oReqReady),
    .oTabData(oTabData),
    .iTabData(tabOut),
    .oRspValid(oRspValid),
    .oRspData(oRspData),
    .iRspReady(iRspReady),
    .oBusy(oBusy)
  );

  always #5 iCLK = ~iCLK;

  function automatic logic [7:0] tabFunc(input logic [7:0] x);
    logic [7:0] t;
    t = x * 8'd5 + 8'd3;
    return t ^ 8'hA5;
  endfunction

  // Registered table: result appears one cycle after its argument.
  always @(posedge iCLK) tabOut <= tabFunc(oTabData);

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int modelGrant();
    for (int k = 0; k < NUM_REQ; k++) begin
      int i;
      i = (mRr + k) % NUM_REQ;
      if (reqVal[i] && mAge[i] == 0 && !mHeld[i]) return i;
    end
    return -1;
  endfunction

  task automatic modelReset();
    mRr  = 0;
    mTab = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      mAge[i]    = 0;
      mArg[i]    = 8'h00;
      mHeld[i]   = 1'b0;
      mRsp[i]    = 8'h00;
      dutWait[i] = 0;
    end
  endtask

  task automatic applyStimulus();
    for (int i = 0; i < NUM_REQ; i++) begin
      iReqValid[i]                   = reqVal[i];
      iReqData[i*WIDTH_X +: WIDTH_X] = reqArg[i];
      iRspReady[i]                   = rspRdy[i];
    end
  endtask

  task automatic checkOutput();
    int g;
    logic [NUM_REQ-1:0] expReady;
    logic [NUM_REQ-1:0] expValid;
    bit expBusy;
    g = modelGrant();
    expReady = '0;
    if (g >= 0) expReady[g] = 1'b1;
    expValid = '0;
    expBusy  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      expValid[i] = mHeld[i];
      if (mHeld[i] || mAge[i] != 0) expBusy = 1'b1;
    end
    checkVal("oReqReady", 32'(oReqReady), 32'(expReady));
    checkVal("oTabData", 32'(oTabData), 32'(mTab));
    checkVal("oRspValid", 32'(oRspValid), 32'(expValid));
    for (int i = 0; i < NUM_REQ; i++) begin
      checkVal($sformatf("oRspData[%0d]", i), 32'(oRspData[i*WIDTH_Y +: WIDTH_Y]), 32'(mRsp[i]));
    end
    checkVal("oBusy", 32'(oBusy), 32'(expBusy));
    if (fairPhase) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (oReqReady[i]) begin
          checkVal($sformatf("fair.alternate%0d", i), 32'(i != lastGrant), 32'd1);
          checkVal($sformatf("fair.wait%0d", i), 32'(dutWait[i] <= NUM_REQ), 32'd1);
          lastGrant  = i;
          dutWait[i] = 0;
        end else if (iReqValid[i]) begin
          dutWait[i]++;
        end
      end
    end
  endtask

  task automatic modelEdge(input int g);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (mHeld[i] && rspRdy[i]) mHeld[i] = 1'b0;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (mAge[i] == 2) begin
        mHeld[i] = 1'b1;
        mRsp[i]  = tabFunc(mArg[i]);
        mAge[i]  = 0;
      end else if (mAge[i] == 1) begin
        mAge[i] = 2;
      end
    end
    if (g >= 0) begin
      mAge[g] = 1;
      mArg[g] = reqArg[g];
      mTab    = reqArg[g];
      mRr     = (g + 1) % NUM_REQ;
      if (autoRenew[g]) reqArg[g] = 8'($urandom);
      else reqVal[g] = 1'b0;
    end
  endtask

  // One cycle: drive at the falling edge, check, let the rising edge happen,
  // advance the model, and return at the next falling edge.
  task automatic step();
    int g;
    applyStimulus();
    #1;
    checkOutput();
    g = modelGrant();
    @(posedge iCLK);
    modelEdge(g);
    @(negedge iCLK);
  endtask

  task automatic doReset();
    for (int i = 0; i < NUM_REQ; i++) begin
      reqVal[i]    = 1'b0;
      autoRenew[i] = 1'b0;
    end
    applyStimulus();
    iRST_N = 1'b0;
    #1;
    modelReset();
    checkOutput();
    @(negedge iCLK);
    iRST_N = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < NUM_REQ; i++) begin
      reqVal[i] = 1'b0; reqArg[i] = 8'h00; rspRdy[i] = 1'b1; autoRenew[i] = 1'b0;
    end
    modelReset();
    applyStimulus();
    @(negedge iCLK);
    #1;
    $display("[TB] reset state");
    checkOutput();
    checkVal("reset.busy", 32'(oBusy), 32'd0);
    @(negedge iCLK);
    iRST_N = 1'b1;

    $display("[TB] single request");
    reqVal[2] = 1'b1; reqArg[2] = 8'h40;
    applyStimulus();
    #1;
    checkVal("single.grant", 32'(oReqReady), 32'b0100);
    step();
    checkVal("single.tab", 32'(oTabData), 32'h40);
    step();
    step();
    checkVal("single.rspValid", 32'(oRspValid[2]), 32'd1);
    checkVal("single.rspData", 32'(oRspData[2*WIDTH_Y +: WIDTH_Y]), 32'(tabFunc(8'h40)));
    step();
    checkVal("single.cleared", 32'(oRspValid[2]), 32'd0);
    checkVal("single.idleBusy", 32'(oBusy), 32'd0);

    $display("[TB] full contention");
    doReset();
    for (int i = 0; i < NUM_REQ; i++) begin
      reqVal[i] = 1'b1; reqArg[i] = 8'($urandom); autoRenew[i] = 1'b1;
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      applyStimulus();
      #1;
      checkVal($sformatf("contend.grant%0d", k), 32'(oReqReady), 32'(1 << k));
      step();
    end
    for (int k = 0; k < 8; k++) step();
    for (int i = 0; i < NUM_REQ; i++) autoRenew[i] = 1'b0;
    for (int k = 0; k < 12; k++) step();

    $display("[TB] back-pressure on requester 1");
    for (int i = 0; i < NUM_REQ; i++) begin
      reqVal[i] = 1'b1; reqArg[i] = 8'($urandom); autoRenew[i] = 1'b1;
    end
    rspRdy[1] = 1'b0;
    for (int k = 0; k < 10; k++) step();
    checkVal("bp.held", 32'(oRspValid[1]), 32'd1);
    rspRdy[1] = 1'b1;
    for (int k = 0; k < 6; k++) step();
    for (int i = 0; i < NUM_REQ; i++) autoRenew[i] = 1'b0;
    for (int k = 0; k < 12; k++) step();

    $display("[TB] fairness between requesters 0 and 3");
    reqVal[0] = 1'b1; reqArg[0] = 8'($urandom); autoRenew[0] = 1'b1;
    reqVal[3] = 1'b1; reqArg[3] = 8'($urandom); autoRenew[3] = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) dutWait[i] = 0;
    lastGrant = -1;
    fairPhase = 1'b1;
    for (int k = 0; k < 24; k++) step();
    fairPhase = 1'b0;
    autoRenew[0] = 1'b0; autoRenew[3] = 1'b0;
    for (int k = 0; k < 10; k++) step();

    $display("[TB] reset mid-flight");
    reqVal[1] = 1'b1; reqArg[1] = 8'h5C;
    step();
    step();
    for (int i = 0; i < NUM_REQ; i++) reqVal[i] = 1'b0;
    applyStimulus();
    iRST_N = 1'b0;
    #1;
    checkVal("rst.ready", 32'(oReqReady), 32'd0);
    checkVal("rst.tab", 32'(oTabData), 32'd0);
    checkVal("rst.rspValid", 32'(oRspValid), 32'd0);
    checkVal("rst.rspData", 32'(oRspData), 32'd0);
    checkVal("rst.busy", 32'(oBusy), 32'd0);
    modelReset();
    @(posedge iCLK);
    @(negedge iCLK);
    #1;
    checkVal("rst.noRsp", 32'(oRspValid), 32'd0);
    iRST_N = 1'b1;
    for (int k = 0; k < 4; k++) step();
    reqVal[1] = 1'b1; reqArg[1] = 8'h11;
    reqVal[3] = 1'b1; reqArg[3] = 8'h33;
    applyStimulus();
    #1;
    checkVal("rst.firstGrant", 32'(oReqReady), 32'b0010);
    for (int k = 0; k < 10; k++) step();

    $display("[TB] idle");
    for (int k = 0; k < 20; k++) step();
    checkVal("idle.tab", 32'(oTabData), 32'(mTab));
    checkVal("idle.busy", 32'(oBusy), 32'd0);

    $display("[TB] random traffic");
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!reqVal[i] && $urandom_range(0, 2) == 0) begin
          reqVal[i] = 1'b1;
          reqArg[i] = 8'($urandom);
        end
        rspRdy[i] = ($urandom_range(0, 3) != 0);
      end
      step();
    end
    for (int i = 0; i < NUM_REQ; i++) rspRdy[i] = 1'b1;
    for (int k = 0; k < 12; k++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
